axis_chan_counter: RTL and testbench
====================================

Name: axis_chan_counter

Overview:
Passive multi-channel AXI-stream traffic counter: a parametrised successor to the single free-running counter on an axis slave. It taps a stream's handshake signals and keeps per-channel beat and frame counts, selected by tdest. Counts are gated by enable, clearable, and read through a registered snapshot port. It sits beside any axis link in a test unit for debug and bandwidth checks, and never drives tready.

Parameters:
NCH, 4, number of channels; tdest values 0..NCH-1 are counted, others are ignored
CNT_W, 10, beat-counter width in bits
FRM_W, 8, frame-counter width in bits
SAT_MODE, 0, 0 = counters wrap modulo 2^W; 1 = counters saturate at all-ones
DEST_W, $clog2(NCH) (minimum 1), width of tdest and of the snapshot channel select

Ports:
clock  input  1  single clock
rst  input  1  asynchronous reset, active-high
enable  input  1  counting gate; when 0, no counter changes
clear  input  1  synchronous clear of all channels' counters and overflow flags
axis_tvalid  input  1  monitored tvalid
axis_tready  input  1  monitored tready
axis_tlast  input  1  monitored tlast
axis_tdest  input  DEST_W  monitored tdest (channel select)
snap_req  input  1  one-cycle request to read one channel
snap_ch  input  DEST_W  channel to read
snap_valid  output  1  snapshot outputs valid, one-cycle pulse
snap_beats  output  CNT_W  beat count of the requested channel
snap_frames  output  FRM_W  frame count of the requested channel
snap_ovf  output  1  sticky wrap/saturate flag of the requested channel
busy  output  1  high while a frame is open on any channel (tlast not yet seen)

Behaviour:
- Reset (asynchronous, rst=1): all counters, overflow flags and open-frame bits = 0; snap_valid=0; snap_beats/snap_frames/snap_ovf=0; busy=0.
- Beat event: axis_tvalid & axis_tready & enable & (axis_tdest < NCH). The beat counter of channel tdest increments on the next clock edge (1-cycle latency).
- Frame event: a beat event with axis_tlast=1. The channel's frame counter increments on the same edge as its beat counter.
- Per-channel open-frame bit: set on a beat with tlast=0 and cleared on a beat with tlast=1. busy is the registered OR of all open-frame bits.
- Wrap mode (SAT_MODE=0): all-ones + 1 -> 0 and sets that counter's channel ovf.
- Saturate mode (SAT_MODE=1): the counter holds at all-ones and sets ovf on the first attempted increment past it.
- Each channel has one ovf flag covering both its beat and frame counters. The flag is sticky until clear or rst.
- clear has priority over a same-cycle beat event: after the edge, all counters = 0 and the beat is lost.
- Snapshot: snap_req in cycle N produces snap_valid=1 in cycle N+1. Data reflects counter values after cycle N's update, so a same-cycle beat is included (read-after-update bypass).
- An out-of-range snap_ch returns zeros with snap_valid=1.
- Simultaneous clear and snap_req: the snapshot returns zeros.
- enable=0: counters, flags and open-frame bits all hold. Snapshot still works.
- Back-to-back snap_req every cycle is supported.

Optional Feature:
- Macro: AXIS_CHAN_COUNTER_STALL_EN.
- When defined: adds output snap_stalls (width CNT_W) and a per-channel stall counter. It increments on tvalid & ~tready & enable with an in-range tdest, follows the same wrap/saturate, clear and snapshot rules, and ORs into ovf.
- When undefined: no stall logic, and the port is absent.

Decomposition:
- Package axis_cnt_pkg:
  - enum cnt_mode_e {CNT_WRAP, CNT_SAT}
  - function sat_inc(value, mode) returning next value and overflow bit
  - per-channel record typedef, parametrised by width through the package function interface
- Sub-module axis_cnt_cell:
  - one channel's beat, frame and optional stall counters, plus its ovf and open-frame bits
  - instantiated NCH times in a generate loop
  - the top level holds only event decode, the snapshot mux/register and busy

Test Plan:
- Reset/idle: assert rst mid-stream after 5 beats -> all snap reads return beats=0, frames=0, ovf=0, busy=0.
- Per-channel routing: NCH=4, send 3 beats on tdest=2 with tlast on the 3rd, and 1 beat on tdest=0 with tlast=0 -> ch2 = {3, 1}, ch0 = {1, 0}, busy=1 until a tlast beat is sent on ch0.
- Wrap vs saturate: CNT_W=4, 17 beats on ch1 -> SAT_MODE=0 gives beats=1, ovf=1; SAT_MODE=1 gives beats=15, ovf=1.
- Gating: tvalid=1, tready=0 for 10 cycles, then enable=0 with 5 handshakes -> beats unchanged (stall counter = 10 when AXIS_CHAN_COUNTER_STALL_EN is defined).
- Same-cycle events: a beat on ch3 with snap_req on ch3 -> the snapshot includes that beat. A beat plus clear in the same cycle -> beats=0. tdest=5 on NCH=4 -> no channel changes.
- Snapshot throughput: snap_req on 4 consecutive cycles for ch0..3 -> snap_valid high for 4 consecutive cycles with the correct per-channel data.

Source files
------------

// File: rtl/axis_cnt_pkg.sv
// Shared types and helpers for the axis_chan_counter traffic monitor.
// The optional stall counters are enabled by defining AXIS_CHAN_COUNTER_STALL_EN.
package axis_cnt_pkg;

    // Widest counter this package can handle; cells zero-extend into it.
    localparam int MAX_W = 32;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Result of one counter increment attempt.
    typedef struct packed {
        logic [MAX_W-1:0] value;
        logic             ovf;
    } inc_res_t;

    // Per-channel record, fields zero-extended to MAX_W.
    typedef struct packed {
        logic [MAX_W-1:0] beats;
        logic [MAX_W-1:0] frames;
        logic [MAX_W-1:0] stalls;
        logic             ovf;
        logic             open;
    } chan_rec_t;

    // All-ones pattern in the low 'width' bits.
    function automatic logic [MAX_W-1:0] ones_mask(input int width);
        logic [MAX_W-1:0] m;
        for (int i = 0; i < MAX_W; i++) begin
            m[i] = (i < width);
        end
        return m;
    endfunction

    // Increment a 'width'-bit counter, wrapping or saturating at all-ones.
    function automatic inc_res_t sat_inc(input logic [MAX_W-1:0] value,
                                         input int               width,
                                         input cnt_mode_e        mode);
        inc_res_t         r;
        logic [MAX_W-1:0] top;
        top     = ones_mask(width);
        r.value = value + MAX_W'(1);
        r.ovf   = 1'b0;
        if (value == top) begin
            r.ovf   = 1'b1;
            r.value = (mode == CNT_SAT) ? top : '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_cnt_cell.sv
// One channel of axis_chan_counter: beat, frame and (with
// AXIS_CHAN_COUNTER_STALL_EN) stall counters, a sticky overflow flag and
// the open-frame bit. Exposes its next-state record so the parent can
// snapshot values that include the current cycle's update.
module axis_cnt_cell
    import axis_cnt_pkg::*;
#(
    parameter int        CNT_W = 10,
    parameter int        FRM_W = 8,
    parameter cnt_mode_e MODE  = CNT_WRAP
) (
    input  logic      clock,
    input  logic      rst,
    input  logic      clear,
    input  logic      beat_ev,
    input  logic      last,
`ifdef AXIS_CHAN_COUNTER_STALL_EN
    input  logic      stall_ev,
`endif
    output chan_rec_t next_rec
);

    logic [CNT_W-1:0] beats_q, beats_d;
    logic [FRM_W-1:0] frames_q, frames_d;
    logic             ovf_q, ovf_d;
    logic             open_q, open_d;
    inc_res_t         beat_inc, frame_inc;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
    logic [CNT_W-1:0] stalls_q, stalls_d;
    inc_res_t         stall_inc;
`endif
    logic             unused_inc_hi;

    // Candidate incremented values for each counter.
    always_comb begin
        beat_inc  = sat_inc(MAX_W'(beats_q), CNT_W, MODE);
        frame_inc = sat_inc(MAX_W'(frames_q), FRM_W, MODE);
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        stall_inc = sat_inc(MAX_W'(stalls_q), CNT_W, MODE);
`endif
    end

`ifdef AXIS_CHAN_COUNTER_STALL_EN
    assign unused_inc_hi = ^{beat_inc.value >> CNT_W, frame_inc.value >> FRM_W,
                             stall_inc.value >> CNT_W};
`else
    assign unused_inc_hi = ^{beat_inc.value >> CNT_W, frame_inc.value >> FRM_W};
`endif

    // Next-state: clear wins over any same-cycle event; open bit only moves on beats.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
        beats_d  = beats_q;
        frames_d = frames_q;
        ovf_d    = ovf_q;
        open_d   = open_q;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        stalls_d = stalls_q;
`endif
        if (clear) begin
            beats_d  = '0;
            frames_d = '0;
            ovf_d    = 1'b0;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            stalls_d = '0;
`endif
        end else begin
            if (beat_ev) begin
                beats_d = beat_inc.value[CNT_W-1:0];
                ovf_d   = ovf_d | beat_inc.ovf;
                open_d  = ~last;
                if (last) begin
                    frames_d = frame_inc.value[FRM_W-1:0];
                    ovf_d    = ovf_d | frame_inc.ovf;
                end
            end
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            if (stall_ev) begin
                stalls_d = stall_inc.value[CNT_W-1:0];
                ovf_d    = ovf_d | stall_inc.ovf;
            end
`endif
        end
    end

    // Channel state registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            beats_q  <= '0;
            frames_q <= '0;
            ovf_q    <= 1'b0;
            open_q   <= 1'b0;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            stalls_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops sample pre-edge values together.
            beats_q  <= beats_d;
            frames_q <= frames_d;
            ovf_q    <= ovf_d;
            open_q   <= open_d;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            stalls_q <= stalls_d;
`endif
        end
    end

    // Publish the post-update values, zero-extended into the shared record.
    always_comb begin
        next_rec        = '0;
        next_rec.beats  = MAX_W'(beats_d);
        next_rec.frames = MAX_W'(frames_d);
        next_rec.ovf    = ovf_d;
        next_rec.open   = open_d;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        next_rec.stalls = MAX_W'(stalls_d);
`endif
    end

endmodule

// File: rtl/axis_chan_counter.sv
// Passive per-channel AXI-stream beat/frame counter with a registered
// snapshot read port. Never drives tready. Optional stall counters are
// enabled by defining AXIS_CHAN_COUNTER_STALL_EN (adds port snap_stalls).
module axis_chan_counter
    import axis_cnt_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CNT_W    = 10,
    parameter int FRM_W    = 8,
    parameter int SAT_MODE = 0,
    parameter int DEST_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              axis_tvalid,
    input  logic              axis_tready,
    input  logic              axis_tlast,
    input  logic [DEST_W-1:0] axis_tdest,
    input  logic              snap_req,
    input  logic [DEST_W-1:0] snap_ch,
    output logic              snap_valid,
    output logic [CNT_W-1:0]  snap_beats,
    output logic [FRM_W-1:0]  snap_frames,
    output logic              snap_ovf,
`ifdef AXIS_CHAN_COUNTER_STALL_EN
    output logic [CNT_W-1:0]  snap_stalls,
`endif
    output logic              busy
);

    localparam cnt_mode_e MODE  = (SAT_MODE != 0) ? CNT_SAT : CNT_WRAP;
    // Full decode range of tdest; slots at NCH and above stay empty.
    localparam int        NSLOT = 1 << DEST_W;

    logic      tdest_ok;
    logic      snap_ok;
    logic      beat_any;
    logic      stall_any;
    chan_rec_t rec_next [NSLOT];
    chan_rec_t sel_rec;
    logic      unused_sel_hi;

    logic             snap_valid_q, snap_valid_d;
    logic [CNT_W-1:0] snap_beats_q, snap_beats_d;
    logic [FRM_W-1:0] snap_frames_q, snap_frames_d;
    logic             snap_ovf_q, snap_ovf_d;
    logic             busy_q, busy_d;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
    logic [CNT_W-1:0] snap_stalls_q, snap_stalls_d;
`endif

    // Event decode shared by all channels.
    always_comb begin
        tdest_ok  = 32'(axis_tdest) < 32'(NCH);
        snap_ok   = 32'(snap_ch) < 32'(NCH);
        beat_any  = axis_tvalid & axis_tready & enable & tdest_ok;
        stall_any = axis_tvalid & ~axis_tready & enable & tdest_ok;
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_chan
        if (g < NCH) begin : g_cell
            axis_cnt_cell #(
                .CNT_W (CNT_W),
                .FRM_W (FRM_W),
                .MODE  (MODE)
            ) u_cell (
                .clock    (clock),
                .rst      (rst),
                .clear    (clear),
                .beat_ev  (beat_any & (axis_tdest == DEST_W'(g))),
                .last     (axis_tlast),
`ifdef AXIS_CHAN_COUNTER_STALL_EN
                .stall_ev (stall_any & (axis_tdest == DEST_W'(g))),
`endif
                .next_rec (rec_next[g])
            );
        end else begin : g_empty
            assign rec_next[g] = '0;
        end
    end

`ifndef AXIS_CHAN_COUNTER_STALL_EN
    logic unused_stall_any;
    assign unused_stall_any = stall_any;
`endif

    // Snapshot mux reads next-state values so a same-cycle beat or clear is reflected.
    always_comb begin
        sel_rec       = rec_next[snap_ch];
        snap_valid_d  = snap_req;
        snap_beats_d  = snap_beats_q;
        snap_frames_d = snap_frames_q;
        snap_ovf_d    = snap_ovf_q;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        snap_stalls_d = snap_stalls_q;
`endif
        if (snap_req) begin
            snap_beats_d  = snap_ok ? sel_rec.beats[CNT_W-1:0]  : '0;
            snap_frames_d = snap_ok ? sel_rec.frames[FRM_W-1:0] : '0;
            snap_ovf_d    = snap_ok ? sel_rec.ovf               : 1'b0;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            snap_stalls_d = snap_ok ? sel_rec.stalls[CNT_W-1:0] : '0;
`endif
        end
    end

`ifdef AXIS_CHAN_COUNTER_STALL_EN
    assign unused_sel_hi = ^{sel_rec.beats >> CNT_W, sel_rec.frames >> FRM_W,
                             sel_rec.stalls >> CNT_W, sel_rec.open};
`else
    assign unused_sel_hi = ^{sel_rec.beats >> CNT_W, sel_rec.frames >> FRM_W,
                             sel_rec.stalls, sel_rec.open};
`endif

    // busy tracks the open-frame bits as they will be after this edge.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            busy_d = busy_d | rec_next[i].open;
        end
    end

    // Snapshot and busy output registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            snap_valid_q  <= 1'b0;
            snap_beats_q  <= '0;
            snap_frames_q <= '0;
            snap_ovf_q    <= 1'b0;
            busy_q        <= 1'b0;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            snap_stalls_q <= '0;
`endif
        end else begin
            snap_valid_q  <= snap_valid_d;
            snap_beats_q  <= snap_beats_d;
            snap_frames_q <= snap_frames_d;
            snap_ovf_q    <= snap_ovf_d;
            busy_q        <= busy_d;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            snap_stalls_q <= snap_stalls_d;
`endif
        end
    end

    assign snap_valid  = snap_valid_q;
    assign snap_beats  = snap_beats_q;
    assign snap_frames = snap_frames_q;
    assign snap_ovf    = snap_ovf_q;
    assign busy        = busy_q;
`ifdef AXIS_CHAN_COUNTER_STALL_EN
    assign snap_stalls = snap_stalls_q;
`endif

endmodule

// File: tb/tb_axis_chan_counter.sv
// Self-checking bench for axis_chan_counter: three instances (4-bit wrap,
// 4-bit saturate, NCH=3 with default widths) share one stimulus stream and
// are compared against an integer reference model of the channel rules.
module tb_axis_chan_counter;

    localparam int NI = 3;
    localparam int P_NCH [NI] = '{4, 4, 3};
    localparam int P_CW  [NI] = '{4, 4, 10};
    localparam int P_FW  [NI] = '{3, 3, 8};
    localparam int P_SAT [NI] = '{0, 1, 0};

    logic       clock = 1'b0;
    logic       rst;
    logic       enable, clear;
    logic       axis_tvalid, axis_tready, axis_tlast;
    logic [1:0] axis_tdest;
    logic       snap_req;
    logic [1:0] snap_ch;

    logic       a_valid, a_ovf, a_busy;
    logic [3:0] a_beats, a_stalls;
    logic [2:0] a_frames;
    logic       b_valid, b_ovf, b_busy;
    logic [3:0] b_beats, b_stalls;
    logic [2:0] b_frames;
    logic       c_valid, c_ovf, c_busy;
    logic [9:0] c_beats, c_stalls;
    logic [7:0] c_frames;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model state: plain integers per instance and channel.
    int m_beats  [NI][4];
    int m_frames [NI][4];
    int m_stalls [NI][4];
    bit m_ovf    [NI][4];
    bit m_open   [NI][4];

    initial forever #5 clock = ~clock;

    axis_chan_counter #(.NCH(4), .CNT_W(4), .FRM_W(3), .SAT_MODE(0)) u_wrap (
        .clock(clock), .rst(rst), .enable(enable), .clear(clear),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
        .axis_tdest(axis_tdest), .snap_req(snap_req), .snap_ch(snap_ch),
        .snap_valid(a_valid), .snap_beats(a_beats), .snap_frames(a_frames),
        .snap_ovf(a_ovf),
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        .snap_stalls(a_stalls),
`endif
        .busy(a_busy));

    axis_chan_counter #(.NCH(4), .CNT_W(4), .FRM_W(3), .SAT_MODE(1)) u_sat (
        .clock(clock), .rst(rst), .enable(enable), .clear(clear),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
        .axis_tdest(axis_tdest), .snap_req(snap_req), .snap_ch(snap_ch),
        .snap_valid(b_valid), .snap_beats(b_beats), .snap_frames(b_frames),
        .snap_ovf(b_ovf),
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        .snap_stalls(b_stalls),
`endif
        .busy(b_busy));

    axis_chan_counter #(.NCH(3)) u_n3 (
        .clock(clock), .rst(rst), .enable(enable), .clear(clear),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
        .axis_tdest(axis_tdest), .snap_req(snap_req), .snap_ch(snap_ch),
        .snap_valid(c_valid), .snap_beats(c_beats), .snap_frames(c_frames),
        .snap_ovf(c_ovf),
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        .snap_stalls(c_stalls),
`endif
        .busy(c_busy));

`ifndef AXIS_CHAN_COUNTER_STALL_EN
    initial begin
        a_stalls = '0;
        b_stalls = '0;
        c_stalls = '0;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counter step from the rules: count up, and past all-ones either wrap or pin.
    function automatic int bump(input int v, input int w, input bit sat, inout bit ovf);
        int lim;
        lim = 1 << w;
        if (v + 1 < lim) return v + 1;
        ovf = 1'b1;
        return sat ? lim - 1 : (v + 1) % lim;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
                m_beats[k][c]  = 0;
                m_frames[k][c] = 0;
                m_stalls[k][c] = 0;
                m_ovf[k][c]    = 1'b0;
                m_open[k][c]   = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input bit v, input bit r, input bit l, input int d,
                              input bit en, input bit clr);
        for (int k = 0; k < NI; k++) begin
            if (clr) begin
                for (int c = 0; c < 4; c++) begin
                    m_beats[k][c]  = 0;
                    m_frames[k][c] = 0;
                    m_stalls[k][c] = 0;
                    m_ovf[k][c]    = 1'b0;
                end
            end else if (en && d < P_NCH[k] && v) begin
                if (r) begin
                    m_beats[k][d] = bump(m_beats[k][d], P_CW[k], P_SAT[k] != 0, m_ovf[k][d]);
                    if (l) m_frames[k][d] = bump(m_frames[k][d], P_FW[k], P_SAT[k] != 0, m_ovf[k][d]);
                    m_open[k][d] = !l;
                end else begin
`ifdef AXIS_CHAN_COUNTER_STALL_EN
                    m_stalls[k][d] = bump(m_stalls[k][d], P_CW[k], P_SAT[k] != 0, m_ovf[k][d]);
`endif
                end
            end
        end
    endtask

    task automatic get_obs(input int k, output logic [31:0] v, output logic [31:0] b,
                           output logic [31:0] f, output logic [31:0] o,
                           output logic [31:0] s, output logic [31:0] bz);
        case (k)
            0: begin v = 32'(a_valid); b = 32'(a_beats); f = 32'(a_frames);
                     o = 32'(a_ovf); s = 32'(a_stalls); bz = 32'(a_busy); end
            1: begin v = 32'(b_valid); b = 32'(b_beats); f = 32'(b_frames);
                     o = 32'(b_ovf); s = 32'(b_stalls); bz = 32'(b_busy); end
            default: begin v = 32'(c_valid); b = 32'(c_beats); f = 32'(c_frames);
                     o = 32'(c_ovf); s = 32'(c_stalls); bz = 32'(c_busy); end
        endcase
    endtask

    task automatic check_inst(input int k, input bit sreq, input int sch);
        logic [31:0] v, b, f, o, s, bz;
        bit          exp_busy;
        bit          in_rng;
        get_obs(k, v, b, f, o, s, bz);
        exp_busy = 1'b0;
        for (int c = 0; c < P_NCH[k]; c++) exp_busy |= m_open[k][c];
        check($sformatf("i%0d busy", k), bz, 32'(exp_busy));
        check($sformatf("i%0d snap_valid", k), v, 32'(sreq));
        if (sreq) begin
            in_rng = sch < P_NCH[k];
            check($sformatf("i%0d ch%0d beats", k, sch), b, in_rng ? m_beats[k][sch] : 0);
            check($sformatf("i%0d ch%0d frames", k, sch), f, in_rng ? m_frames[k][sch] : 0);
            check($sformatf("i%0d ch%0d ovf", k, sch), o, in_rng ? 32'(m_ovf[k][sch]) : 0);
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            check($sformatf("i%0d ch%0d stalls", k, sch), s, in_rng ? m_stalls[k][sch] : 0);
`endif
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] v, b, f, o, s, bz;
        for (int k = 0; k < NI; k++) begin
            get_obs(k, v, b, f, o, s, bz);
            check($sformatf("%s i%0d snap_valid", tag, k), v, 0);
            check($sformatf("%s i%0d beats", tag, k), b, 0);
            check($sformatf("%s i%0d frames", tag, k), f, 0);
            check($sformatf("%s i%0d ovf", tag, k), o, 0);
            check($sformatf("%s i%0d busy", tag, k), bz, 0);
`ifdef AXIS_CHAN_COUNTER_STALL_EN
            check($sformatf("%s i%0d stalls", tag, k), s, 0);
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input bit v, input bit r, input bit l, input int d,
                         input bit en, input bit clr, input bit sreq, input int sch);
        axis_tvalid = v;
        axis_tready = r;
        axis_tlast  = l;
        axis_tdest  = 2'(d);
        enable      = en;
        clear       = clr;
        snap_req    = sreq;
        snap_ch     = 2'(sch);
        @(posedge clock);
        model_edge(v, r, l, d, en, clr);
        #1;
        for (int k = 0; k < NI; k++) check_inst(k, sreq, sch);
    endtask

    task automatic idle_snap(input int sch);
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, sch);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1; clear = 1'b0;
        axis_tvalid = 1'b0; axis_tready = 1'b0; axis_tlast = 1'b0; axis_tdest = '0;
        snap_req = 1'b0; snap_ch = '0;
        model_reset();
        #1;
        check_all_zero("reset");
        @(negedge clock);
        rst = 1'b0;

        // Five beats mid-frame, then an asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, $urandom_range(0, 2), 1'b1, 1'b0, 1'b0, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all_zero("mid reset");
        @(negedge clock);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) idle_snap(c);

        // Routing: ch2 gets a 3-beat frame, ch0 an open beat.
        cycle(1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        idle_snap(2);
        check("route ch2 beats", 32'(a_beats), 3);
        check("route ch2 frames", 32'(a_frames), 1);
        idle_snap(0);
        check("route ch0 beats", 32'(a_beats), 1);
        check("route ch0 frames", 32'(a_frames), 0);
        check("route busy open", 32'(a_busy), 1);
        cycle(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0);
        check("route busy closed", 32'(a_busy), 0);

        // Wrap versus saturate: 17 beats on ch1.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 0);
        idle_snap(1);
        check("wrap beats", 32'(a_beats), 1);
        check("wrap ovf", 32'(a_ovf), 1);
        check("sat beats", 32'(b_beats), 15);
        check("sat ovf", 32'(b_ovf), 1);

        // Gating: ten stalled cycles, then five handshakes with enable low.
        cycle(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 0);
        idle_snap(0);
        check("gate beats", 32'(a_beats), 0);
`ifdef AXIS_CHAN_COUNTER_STALL_EN
        check("gate stalls", 32'(a_stalls), 10);
`endif

        // Same-cycle beat and snapshot, then beat plus clear plus snapshot.
        cycle(1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 3);
        check("bypass ch3 beats", 32'(a_beats), 1);
        cycle(1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 3);
        check("clear beat lost", 32'(a_beats), 0);
        idle_snap(3);
        // tdest=3 is outside the three-channel instance.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 3);
        check("oor n3 beats", 32'(c_beats), 0);

        // Back-to-back snapshots of all channels with traffic running.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, 1'b0, 0);
        for (int c = 0; c < 4; c++) cycle(1'b1, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, 1'b1, c);

        // Randomized traffic, gating, clears and snapshots.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0,
                  1'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
